// File: rtl/wb_pipe_stage.sv
// Write-back stage: registers one MEM result, extends load data and drives the register-file write
// and forwarding ports. Defining WB_RETIRE_CNT_EN adds the retire_cnt output and its counter.
module wb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ir_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] lmd_in,
    input  logic              stall,
    input  logic              flush,
    output logic              wb_en,
    output logic [AW-1:0]     wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [AW-1:0]     fwd_addr,
    output logic [DATA_W-1:0] fwd_data
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]  retire_cnt
`endif
);

    localparam logic [2:0] CLS_ALU  = 3'b000;
    localparam logic [2:0] CLS_LOAD = 3'b001;

    function automatic logic [DATA_W-1:0] load_ext(input logic [1:0] sz, input logic [DATA_W-1:0] raw);
        logic signed [15:0] half_s;
        logic signed [7:0]  byte_s;
        half_s = raw[15:0];
        byte_s = raw[7:0];
        case (sz)
            2'b00:   load_ext = raw;
            2'b01:   load_ext = DATA_W'(half_s);
            2'b10:   load_ext = DATA_W'(byte_s);
            default: load_ext = DATA_W'(raw[7:0]);
        endcase
    endfunction

    logic [2:0]        cls;
    logic [AW-1:0]     addr_d, addr_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic              wr_d, wr_q;
    logic              valid_d, valid_q;
    logic              done_d, done_q;
    logic              xfer;
    logic              retire;

    always_comb begin
        cls    = ir_in[31:29];
        addr_d = (cls == CLS_LOAD) ? AW'(ir_in[20:16]) : AW'(ir_in[15:11]);
        wr_d   = ((cls == CLS_ALU) || (cls == CLS_LOAD)) && (addr_d != '0);
        data_d = (cls == CLS_LOAD) ? load_ext(ir_in[28:27], lmd_in) : alu_in;
    end

    assign in_ready = !stall;
    assign xfer     = in_valid && !stall && !flush;
    // An entry retires on its first presented non-stall, non-flush cycle, and only once.
    assign retire   = valid_q && !done_q && !stall && !flush;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q | retire;
        if (flush) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Payload is qualified by valid_q, so it is captured without reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign wb_en     = retire && wr_q;
    assign wb_addr   = wb_en ? addr_q : '0;
    assign wb_data   = wb_en ? data_q : '0;
    assign fwd_valid = valid_q && wr_q;
    assign fwd_addr  = fwd_valid ? addr_q : '0;
    assign fwd_data  = fwd_valid ? data_q : '0;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: fixed vectors, hand sequences for stall/flush/reset/counter wrap, random run vs model.
module tb_wb_pipe_stage;

    localparam int DATA_W = 32;
    localparam int AW     = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, in_valid, stall, flush;
    logic [31:0]       ir_in;
    logic [DATA_W-1:0] alu_in, lmd_in;
    logic              in_ready, wb_en, fwd_valid;
    logic [AW-1:0]     wb_addr, fwd_addr;
    logic [DATA_W-1:0] wb_data, fwd_data;
`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0]  retire_cnt;
`endif

    wb_pipe_stage #(.DATA_W(DATA_W), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ir_in(ir_in), .alu_in(alu_in), .lmd_in(lmd_in), .stall(stall), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] alu;
        logic [31:0] lmd;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[10];

    int checks   = 0;
    int failures = 0;
    int pulses;
    int cnt_before;

    // Reference model: one held entry described by what it will do when presented.
    bit          m_valid, m_done, m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_data(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] lmd);
        int v;
        if ((ir >> 29) == 0) return alu;
        case ((ir >> 27) & 3)
            0: return lmd;
            1: begin v = int'(lmd & 32'hFFFF); if (v >= 32768) v -= 65536; return 32'(v); end
            2: begin v = int'(lmd & 32'hFF);   if (v >= 128)   v -= 256;   return 32'(v); end
            default: return lmd & 32'hFF;
        endcase
    endfunction

    task automatic check_cycle();
        bit e_en, e_fwd;
        @(negedge clk);
        e_en  = m_valid && !m_done && !stall && !flush && m_wr;
        e_fwd = m_valid && m_wr;
        if (wb_en === 1'b1) pulses++;
        chk("in_ready",  64'(in_ready),  64'(!stall));
        chk("wb_en",     64'(wb_en),     64'(e_en));
        chk("wb_addr",   64'(wb_addr),   e_en ? 64'(m_addr) : 64'd0);
        chk("wb_data",   64'(wb_data),   e_en ? 64'(m_data) : 64'd0);
        chk("fwd_valid", 64'(fwd_valid), 64'(e_fwd));
        chk("fwd_addr",  64'(fwd_addr),  e_fwd ? 64'(m_addr) : 64'd0);
        chk("fwd_data",  64'(fwd_data),  e_fwd ? 64'(m_data) : 64'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
`endif
    endtask

    task automatic advance();
        bit ret;
        int cls, a;
        @(posedge clk);
        ret = m_valid && !m_done && !stall && !flush;
        if (rst) begin
            m_valid = 0; m_done = 0; m_cnt = 0;
        end else begin
            if (ret) begin
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                m_done = 1;
            end
            if (flush) m_valid = 0;
            else if (!stall) begin
                if (in_valid) begin
                    cls     = int'(ir_in >> 29);
                    a       = (cls == 1) ? int'((ir_in >> 16) & 31) : int'((ir_in >> 11) & 31);
                    m_valid = 1;
                    m_done  = 0;
                    m_wr    = (cls <= 1) && (a != 0);
                    m_addr  = 5'(a);
                    m_data  = ref_data(ir_in, alu_in, lmd_in);
                end else m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic cyc();
        check_cycle();
        advance();
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; stall = 0; flush = 0;
    endtask

    task automatic send(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] lmd);
        rst = 0; in_valid = 1; stall = 0; flush = 0;
        ir_in = ir; alu_in = alu; lmd_in = lmd;
    endtask

    initial begin
        vecs[0] = '{32'h0000_5000, 32'h1234_5678, 32'h0,         1'b1, 5'd10, 32'h1234_5678};
        vecs[1] = '{32'h3003_0000, 32'h0,         32'h0000_0080, 1'b1, 5'd3,  32'hFFFF_FF80};
        vecs[2] = '{32'h3803_0000, 32'h0,         32'h0000_0080, 1'b1, 5'd3,  32'h0000_0080};
        vecs[3] = '{32'h2803_0000, 32'h0,         32'h0000_8001, 1'b1, 5'd3,  32'hFFFF_8001};
        vecs[4] = '{32'h2003_0000, 32'h0,         32'hDEAD_BEEF, 1'b1, 5'd3,  32'hDEAD_BEEF};
        vecs[5] = '{32'h0000_0000, 32'h0000_0055, 32'h0,         1'b0, 5'd0,  32'h0};
        vecs[6] = '{32'h4000_5000, 32'h1111_1111, 32'h0,         1'b0, 5'd0,  32'h0};
        vecs[7] = '{32'h201F_0000, 32'h0,         32'h0000_00A5, 1'b1, 5'd31, 32'h0000_00A5};
        vecs[8] = '{32'h0000_F800, 32'hCAFE_F00D, 32'h0,         1'b1, 5'd31, 32'hCAFE_F00D};
        vecs[9] = '{32'h3003_0000, 32'h0,         32'h1234_567F, 1'b1, 5'd3,  32'h0000_007F};

        m_valid = 0; m_done = 0; m_wr = 0; m_addr = 0; m_data = 0; m_cnt = 0;
        ir_in = 0; alu_in = 0; lmd_in = 0;
        idle();
        rst = 1;
        advance();
        advance();
        rst = 0;
        check_cycle();
        chk("reset_wb_en",     64'(wb_en),     64'd0);
        chk("reset_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("reset_wb_data",   64'(wb_data),   64'd0);
        advance();

        // Fixed vectors: transfer, then inspect the write one cycle later.
        for (int i = 0; i < 10; i++) begin
`ifdef WB_RETIRE_CNT_EN
            cnt_before = int'(retire_cnt);
`endif
            send(vecs[i].ir, vecs[i].alu, vecs[i].lmd);
            cyc();
            idle();
            check_cycle();
            chk($sformatf("vec%0d_en", i),   64'(wb_en),   64'(vecs[i].en));
            chk($sformatf("vec%0d_addr", i), 64'(wb_addr), 64'(vecs[i].addr));
            chk($sformatf("vec%0d_data", i), 64'(wb_data), 64'(vecs[i].data));
            chk($sformatf("vec%0d_fwd", i),  64'(fwd_valid), 64'(vecs[i].en));
            advance();
`ifdef WB_RETIRE_CNT_EN
            check_cycle();
            chk($sformatf("vec%0d_retire", i), 64'(retire_cnt), 64'((cnt_before + 1) % 16));
            advance();
`endif
        end

        // Stall held three cycles: one write total, forwarding visible throughout.
        send(32'h0000_2800, 32'hA5A5_0001, 32'h0);
        cyc();
        in_valid = 0; stall = 1; pulses = 0;
        for (int i = 0; i < 3; i++) begin
            check_cycle();
            chk("stall_ready", 64'(in_ready),  64'd0);
            chk("stall_fwd",   64'(fwd_valid), 64'd1);
            chk("stall_faddr", 64'(fwd_addr),  64'd5);
            advance();
        end
        stall = 0;
        cyc();
        cyc();
        chk("stall_single_write", 64'(pulses), 64'd1);

        // Flush during stall kills the held entry without a write.
        send(32'h0000_3000, 32'h0BAD_0BAD, 32'h0);
        cyc();
        in_valid = 1; stall = 1; flush = 1; pulses = 0;
        cyc();
        idle();
        check_cycle();
        chk("flush_wb_en",  64'(wb_en),     64'd0);
        chk("flush_fwd",    64'(fwd_valid), 64'd0);
        advance();
        chk("flush_no_write", 64'(pulses), 64'd0);

        // Flush without stall discards the incoming transfer.
        send(32'h0000_3800, 32'h7777_7777, 32'h0);
        flush = 1;
        cyc();
        idle();
        check_cycle();
        chk("flush_in_wb_en", 64'(wb_en), 64'd0);
        advance();

`ifdef WB_RETIRE_CNT_EN
        rst = 1;
        cyc();
        for (int i = 0; i < 15; i++) begin
            send(32'h4000_0000, 32'h0, 32'h0);
            cyc();
        end
        idle();
        cyc();
        check_cycle();
        chk("cnt_at_15", 64'(retire_cnt), 64'd15);
        advance();
        send(32'h4000_0000, 32'h0, 32'h0);
        cyc();
        idle();
        cyc();
        check_cycle();
        chk("cnt_wrap", 64'(retire_cnt), 64'd0);
        advance();
`endif

        // Reset during stall drops the held entry.
        send(32'h0000_3800, 32'h1357_9BDF, 32'h0);
        cyc();
        in_valid = 0; stall = 1; rst = 1; pulses = 0;
        cyc();
        idle();
        check_cycle();
        chk("rst_mid_wb_en", 64'(wb_en),     64'd0);
        chk("rst_mid_fwd",   64'(fwd_valid), 64'd0);
        chk("rst_mid_addr",  64'(wb_addr),   64'd0);
        advance();
        chk("rst_mid_no_write", 64'(pulses), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            int          c;
            r = $urandom;
            c = int'($urandom_range(0, 5));
            r[31:29] = (c < 2) ? 3'(c) : 3'(c + 1);
            if ($urandom_range(0, 7) == 0) r[20:11] = '0;
            ir_in    = r;
            alu_in   = $urandom;
            lmd_in   = $urandom;
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 11) == 0);
            rst      = ($urandom_range(0, 49) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
